// File: rtl/ttl_74225_sync.sv
`timescale 1ns/1ps
// ttl_74225_sync: single-clock FIFO bus buffer after the 74225, with tri-state head-of-queue output Q.
// Defining TTL74225_HALF_FULL_EN adds a registered-count half-full flag HF.
module ttl_74225_sync #(
  parameter int WIDTH      = 5,
  parameter int DEPTH      = 16,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear_bar,
  input  logic             SI,
  input  logic             SO,
  input  logic             OE_bar,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             IR,
  output logic             OR
`ifdef TTL74225_HALF_FULL_EN
  ,
  output logic             HF
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_HALF = CW'(DEPTH / 2);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_ir;
  logic             w_or;
  logic             w_do_wr;
  logic             w_do_rd;
  logic [WIDTH-1:0] w_q_data;

  assign w_ir = (r_count != C_FULL);
  assign w_or = (r_count != '0);

  // A full FIFO drops the write even when a pop happens on the same edge,
  // and an empty FIFO ignores the pop even when a write arrives.
  assign w_do_wr = Clear_bar && SI && w_ir;
  assign w_do_rd = Clear_bar && SO && w_or;

  // Storage has no reset: contents are only observable through r_rd_ptr
  // while the count says they are valid.
  always_ff @(posedge Clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= D;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clear_bar) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_wr && !w_do_rd) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_rd && !w_do_wr) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Head word falls through as soon as the count is non-zero.
  assign w_q_data = w_or ? r_mem[r_rd_ptr] : '0;

  assign #(DELAY_RISE, DELAY_FALL) Q  = OE_bar ? {WIDTH{1'bz}} : w_q_data;
  assign #(DELAY_RISE, DELAY_FALL) IR = w_ir;
  assign #(DELAY_RISE, DELAY_FALL) OR = w_or;

`ifdef TTL74225_HALF_FULL_EN
  assign #(DELAY_RISE, DELAY_FALL) HF = (r_count >= C_HALF);
`else
  logic w_unused_half;
  assign w_unused_half = ^C_HALF;
`endif

endmodule

// File: tb/tb_ttl_74225_sync.sv
`timescale 1ns/1ps
// Self-checking bench for ttl_74225_sync: queue scoreboard holds expected FIFO contents.
// Also checks HF when TTL74225_HALF_FULL_EN is defined.
module tb_ttl_74225_sync;

  localparam int WIDTH = 5;
  localparam int DEPTH = 16;

  logic             Clk;
  logic             Clear_bar;
  logic             SI;
  logic             SO;
  logic             OE_bar;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             IR;
  logic             OR;
`ifdef TTL74225_HALF_FULL_EN
  logic             HF;
`endif

  logic [WIDTH-1:0] exp_q[$];
  int n_vec;
  int n_err;

  ttl_74225_sync #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .DELAY_RISE(0),
    .DELAY_FALL(0)
  ) dut (
    .Clk(Clk),
    .Clear_bar(Clear_bar),
    .SI(SI),
    .SO(SO),
    .OE_bar(OE_bar),
    .D(D),
    .Q(Q),
    .IR(IR),
    .OR(OR)
`ifdef TTL74225_HALF_FULL_EN
    ,
    .HF(HF)
`endif
  );

  // clock / reset block
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Outputs expected from the scoreboard contents after an edge.
  task automatic check_outputs(input string tag);
    logic [WIDTH-1:0] exp_head;
    exp_head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check({tag, "_ir"}, {7'd0, IR}, {7'd0, exp_q.size() != DEPTH});
    check({tag, "_or"}, {7'd0, OR}, {7'd0, exp_q.size() != 0});
    check({tag, "_q"}, {3'd0, Q}, {3'd0, exp_head});
`ifdef TTL74225_HALF_FULL_EN
    check({tag, "_hf"}, {7'd0, HF}, {7'd0, exp_q.size() >= DEPTH / 2});
`endif
  endtask

  // Driver: apply one edge of stimulus, update the scoreboard, check after the edge.
  task automatic drive(input logic clr_n, input logic si, input logic so,
                       input logic [WIDTH-1:0] d, input string tag);
    logic wr;
    logic rd;
    @(negedge Clk);
    Clear_bar = clr_n;
    SI        = si;
    SO        = so;
    D         = d;
    OE_bar    = 1'b0;
    wr = clr_n && si && (exp_q.size() != DEPTH);
    rd = clr_n && so && (exp_q.size() != 0);
    if (rd) begin
      check({tag, "_pop"}, {3'd0, Q}, {3'd0, exp_q[0]});
    end
    @(posedge Clk);
    if (!clr_n) begin
      exp_q.delete();
    end else begin
      if (rd) void'(exp_q.pop_front());
      if (wr) exp_q.push_back(d);
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic check_hiz(input string tag);
    @(negedge Clk);
    OE_bar = 1'b1;
    #1;
    check(tag, {3'd0, Q}, {3'd0, 5'bzzzzz});
    OE_bar = 1'b0;
    #1;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() != 0) drive(1'b1, 1'b0, 1'b1, '0, tag);
    drive(1'b1, 1'b0, 1'b1, '0, {tag, "_empty"});
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    Clear_bar = 1'b0;
    SI        = 1'b0;
    SO        = 1'b0;
    OE_bar    = 1'b0;
    D         = '0;

    drive(1'b0, 1'b0, 1'b0, '0, "rst0");
    drive(1'b0, 1'b0, 1'b0, '0, "rst1");
    drive(1'b1, 1'b0, 1'b0, '0, "idle");
    check_hiz("hiz_empty");

    drive(1'b1, 1'b1, 1'b0, 5'h01, "wr01");
    drive(1'b1, 1'b0, 1'b1, '0, "rd01");

    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, 1'b0, 5'(i), "fill");
    check("full_ir", {7'd0, IR}, 8'd0);
    drive(1'b1, 1'b1, 1'b0, 5'h1F, "wr_full");
    check_hiz("hiz_full");
    drain("drain16");

    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 5'h03, "pre_wr");
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1, '0, "pre_rd");
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 5'(8'h10 + i), "wrap_wr");
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 5'h1A, "wrap_both");
    check("wrap_head", {3'd0, Q}, 8'h14);
    drain("wrap_drain");

    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, 1'b0, 5'($urandom_range(0, 31)), "fill2");
    drive(1'b1, 1'b1, 1'b1, 5'h1F, "full_both");
    check("full_both_ir", {7'd0, IR}, 8'd1);
    drain("drain15");
    drive(1'b1, 1'b1, 1'b1, 5'h05, "empty_both");
    check("empty_both_q", {3'd0, Q}, 8'h05);
    drain("drain1");

    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 5'(i + 7), "pre_clr");
    drive(1'b0, 1'b1, 1'b0, 5'h1E, "clr_si");
    check("clr_or", {7'd0, OR}, 8'd0);

`ifdef TTL74225_HALF_FULL_EN
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 5'(i), "hf_up");
    check("hf_at8", {7'd0, HF}, 8'd1);
    drive(1'b1, 1'b0, 1'b1, '0, "hf_down");
    check("hf_at7", {7'd0, HF}, 8'd0);
    drive(1'b0, 1'b0, 1'b0, '0, "hf_rst");
`endif

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), "rand");
    end
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
